// File: rtl/seq_divider32.sv
// Iterative restoring divider: one quotient bit per clock, RISC-V M-extension
// semantics for divide-by-zero and signed overflow, start/busy/done handshake.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, FINISH} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q, dmag;
  logic             qneg, rneg;

  logic             accept, a_neg, d_neg, div_zero, ovf, last, carry;
  logic [WIDTH-1:0] a_mag, d_mag;
  logic [WIDTH:0]   r_sh, diff;

  assign accept   = start && (state == IDLE || state == FINISH);
  assign a_neg    = signed_op & dividend[WIDTH-1];
  assign d_neg    = signed_op & divisor[WIDTH-1];
  assign a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
  assign d_mag    = d_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
  assign last     = (cnt == CW'(WIDTH-1));

  // Trial subtraction R' + ~{0,D} + 1; carry-out set means no borrow, keep T.
  assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
  assign {carry, diff} = {1'b0, r_sh} + {1'b0, ~{1'b0, dmag}} + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE, FINISH: begin
        done = (state == FINISH);
        if (accept)                 state_nx = (div_zero || ovf) ? FINISH : CALC;
        else if (state == FINISH)   state_nx = IDLE;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = FINISH;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      dmag      <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (accept) begin
            if (div_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end else if (ovf) begin
              quotient  <= dividend;
              remainder <= '0;
            end else begin
              q    <= a_mag;
              dmag <= d_mag;
              r    <= '0;
              cnt  <= '0;
              qneg <= a_neg ^ d_neg;
              rneg <= a_neg;
            end
          end
        end
        CALC: begin
          q   <= {q[WIDTH-2:0], carry};
          r   <= carry ? diff : r_sh;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          quotient  <= qneg ? (~q + 1'b1) : q;
          remainder <= WIDTH'(rneg ? (~r + 1'b1) : r);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboarded random/directed bench for seq_divider32: stimulus pushes expected
// results from an arithmetic reference, a negedge monitor pops on done.
module tb_seq_divider32;
  logic        clk = 1'b0;
  logic        rst_n, start, signed_op;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        busy, done;

  seq_divider32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q, r;
    int          k, lat, bexp;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0, n_fail = 0;
  int          bcnt = 0;
  logic [31:0] last_q = '0, last_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.k = 0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.lat = 0; e.bexp = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      e.q = a; e.r = '0; e.lat = 0; e.bexp = 0;
    end else begin
      e.lat = 33; e.bexp = 33;
      if (s) begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; start is sampled at the next edge.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    e = model(a, b, s);
    step();
    start = 1'b0;
    e.k = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy) return;
      step();
    end
    n_chk++; n_fail++;
    $display("FAIL drain_timeout: %0d results still pending at cycle %0d", sb.size(), cyc);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) return;
      step();
    end
    n_chk++; n_fail++;
    $display("FAIL done_timeout: done not seen by cycle %0d", cyc);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      bcnt   = 0;
      last_q = '0;
      last_r = '0;
    end else begin
      if (busy) begin
        bcnt++;
        chk("hold_quotient", quotient, last_q);
        chk("hold_remainder", remainder, last_r);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_done: got done=1 expected no result pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("latency", 32'(cyc - e.k), 32'(e.lat));
          chk("busy_cycles", 32'(bcnt), 32'(e.bexp));
          last_q = e.q;
          last_r = e.r;
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          kind;
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) step();
    chk("reset_quotient", quotient, 32'h0);
    chk("reset_remainder", remainder, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    step();

    op(32'd100, 32'd7, 1'b0);                drain();
    op(32'hffff_fff9, 32'd2, 1'b1);          drain();
    op(32'd7, 32'hffff_fffe, 1'b1);          drain();
    op(32'h1234_5678, 32'h0, 1'b0);          drain();
    op(32'h8000_0000, 32'hffff_ffff, 1'b1);  drain();
    op(32'h8000_0000, 32'hffff_ffff, 1'b0);  drain();
    op(32'h0000_0005, 32'h0, 1'b1);          drain();

    // start mid-operation must be ignored
    op(32'd1000, 32'd3, 1'b0);
    repeat (4) step();
    dividend = 32'd55; divisor = 32'd5; signed_op = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    drain();

    // start in the FINISH cycle is accepted back-to-back
    op(32'd12345, 32'd11, 1'b0);
    wait_done();
    op(32'hffff_fc18, 32'd10, 1'b1);
    wait_done();
    op(32'hdead_0000, 32'h0, 1'b0);
    wait_done();
    op(32'd77, 32'd9, 1'b0);
    drain();

    // reset abandons an in-flight division
    op(32'hdead_beef, 32'd3, 1'b0);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_quotient", quotient, 32'h0);
    chk("midrst_remainder", remainder, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    repeat (40) step();
    op(32'hffff_ffff, 32'd1, 1'b0);          drain();

    for (int i = 0; i < 40; i++) begin
      a    = $urandom;
      s    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      case (kind)
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       begin a = 32'h8000_0000; b = 32'hffff_ffff; s = 1'b1; end
        3:       b = 32'hffff_ffff;
        4:       begin a = $urandom_range(0, 1000); b = $urandom; end
        default: b = $urandom;
      endcase
      op(a, b, s);
      if ($urandom_range(0, 1) == 1) wait_done();
      else                           drain();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
